// File: rtl/mem_wait_ctrl.sv
// Wait-state memory controller: bridges a held CPU read/write request onto a
// single-cycle synchronous RAM access after WAIT_CYCLES idle cycles.
module mem_wait_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_BITS   = 10
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [31:0]          db_addr,
  input  logic                 db_read,
  input  logic                 db_write,
  input  logic [31:0]          db_wdata,
  output logic [31:0]          db_rdata,
  output logic                 db_ready,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_re,
  output logic                 ram_we,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata,
  output logic                 busy,
  output logic [15:0]          rd_cnt,
  output logic [15:0]          wr_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_LATCH  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t                 state_r;
  logic [3:0]             wait_cnt_r;
  logic                   is_write_r;
  logic [ADDR_BITS-1:0]   addr_r;
  logic [31:0]            wdata_r;
  logic [31:0]            rdata_r;
  logic                   ready_r;
  logic                   re_r;
  logic                   we_r;
  logic                   busy_r;
  logic [15:0]            rd_cnt_r;
  logic [15:0]            wr_cnt_r;

  assign db_rdata  = rdata_r;
  assign db_ready  = ready_r;
  assign ram_addr  = addr_r;
  assign ram_wdata = wdata_r;
  assign ram_re    = re_r;
  assign ram_we    = we_r;
  assign busy      = busy_r;
  assign rd_cnt    = rd_cnt_r;
  assign wr_cnt    = wr_cnt_r;

  // Transaction FSM; every output is a register set on the transition into its state.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      is_write_r <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= 32'd0;
      rdata_r    <= 32'd0;
      ready_r    <= 1'b0;
      re_r       <= 1'b0;
      we_r       <= 1'b0;
      busy_r     <= 1'b0;
      rd_cnt_r   <= 16'd0;
      wr_cnt_r   <= 16'd0;
    end else begin
      ready_r <= 1'b0;
      re_r    <= 1'b0;
      we_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (db_read || db_write) begin
            // A simultaneous read and write resolves to a write.
            is_write_r <= db_write;
            addr_r     <= db_addr[ADDR_BITS+1:2];
            wdata_r    <= db_wdata;
            busy_r     <= 1'b1;
            if (WAIT_INIT == 4'd0) begin
              state_r <= ST_ACCESS;
              re_r    <= ~db_write;
              we_r    <= db_write;
            end else begin
              state_r    <= ST_WAIT;
              wait_cnt_r <= WAIT_INIT;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          wait_cnt_r <= wait_cnt_r - 4'd1;
          // The <= guard also recovers from a counter that somehow reads zero.
          if (wait_cnt_r <= 4'd1) begin
            state_r    <= ST_ACCESS;
            wait_cnt_r <= 4'd0;
            re_r       <= ~is_write_r;
            we_r       <= is_write_r;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_ACCESS: begin
          state_r <= ST_LATCH;
        end
        ST_LATCH: begin
          if (!is_write_r) begin
            rdata_r <= ram_rdata;
          end else begin
            rdata_r <= rdata_r;
          end
          state_r <= ST_RESP;
          ready_r <= 1'b1;
        end
        ST_RESP: begin
          if (is_write_r) begin
            if (wr_cnt_r != 16'hFFFF) begin
              wr_cnt_r <= wr_cnt_r + 16'd1;
            end else begin
              wr_cnt_r <= wr_cnt_r;
            end
          end else begin
            if (rd_cnt_r != 16'hFFFF) begin
              rd_cnt_r <= rd_cnt_r + 16'd1;
            end else begin
              rd_cnt_r <= rd_cnt_r;
            end
          end
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          wait_cnt_r <= 4'd0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Directed bench for mem_wait_ctrl: WAIT_CYCLES=2 instance plus a WAIT_CYCLES=0 instance.
module tb_mem_wait_ctrl;

  logic        clk;
  logic        res;
  logic [31:0] db_addr, db_wdata, db_rdata, ram_wdata, ram_rdata;
  logic        db_read, db_write, db_ready, ram_re, ram_we, busy;
  logic [9:0]  ram_addr;
  logic [15:0] rd_cnt, wr_cnt;

  logic [31:0] db_addr0, db_rdata0, ram_wdata0, ram_rdata0;
  logic        db_read0, db_ready0, ram_re0, ram_we0, busy0;
  logic [9:0]  ram_addr0;
  logic [15:0] rd_cnt0, wr_cnt0;

  logic [31:0] mem [0:1023];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int ready_cnt = 0, we_cnt = 0, re_cnt = 0, ready_edge = 0;
  logic [31:0] ready_data = 32'd0, we_data = 32'd0;
  logic [9:0]  we_addr = 10'd0, re_addr = 10'd0;
  int ready0_cnt = 0, re0_cnt = 0, ready0_edge = 0;
  logic [31:0] ready0_data = 32'd0;

  mem_wait_ctrl #(.WAIT_CYCLES(2), .ADDR_BITS(10)) dut (
    .clk(clk), .res(res), .db_addr(db_addr), .db_read(db_read), .db_write(db_write),
    .db_wdata(db_wdata), .db_rdata(db_rdata), .db_ready(db_ready), .ram_addr(ram_addr),
    .ram_re(ram_re), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  mem_wait_ctrl #(.WAIT_CYCLES(0), .ADDR_BITS(10)) dut0 (
    .clk(clk), .res(res), .db_addr(db_addr0), .db_read(db_read0), .db_write(1'b0),
    .db_wdata(32'd0), .db_rdata(db_rdata0), .db_ready(db_ready0), .ram_addr(ram_addr0),
    .ram_re(ram_re0), .ram_we(ram_we0), .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0),
    .busy(busy0), .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM models and event monitors; cyc counts rising edges.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      we_cnt  <= we_cnt + 1;
      we_addr <= ram_addr;
      we_data <= ram_wdata;
    end
    if (ram_re) begin
      ram_rdata <= mem[ram_addr];
      re_cnt    <= re_cnt + 1;
      re_addr   <= ram_addr;
    end
    if (db_ready) begin
      ready_cnt  <= ready_cnt + 1;
      ready_edge <= cyc + 1;
      ready_data <= db_rdata;
    end
    if (ram_re0) begin
      ram_rdata0 <= (ram_addr0 == 10'h010) ? 32'hCAFEF00D : 32'h00000000;
      re0_cnt    <= re0_cnt + 1;
    end
    if (db_ready0) begin
      ready0_cnt  <= ready0_cnt + 1;
      ready0_edge <= cyc + 1;
      ready0_data <= db_rdata0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive a request at a negedge, return the edge index that sampled it, then
  // hold it (or drop it after one cycle) until db_ready is seen.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit drop, output int n);
    bit seen;
    @(negedge clk);
    db_read = rd; db_write = wr; db_addr = addr; db_wdata = wdata;
    @(posedge clk); #1;
    n = cyc;
    if (drop) begin
      @(negedge clk);
      db_read = 1'b0; db_write = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (db_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("ready_seen", {31'd0, seen}, 32'd1);
    db_read = 1'b0; db_write = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n, rdy0, we0, re0;
    res = 1'b0; db_read = 1'b0; db_write = 1'b0; db_addr = 32'd0; db_wdata = 32'd0;
    db_read0 = 1'b0; db_addr0 = 32'd0; ram_rdata = 32'd0; ram_rdata0 = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, db_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdata", db_rdata, 32'd0);
    check("rst_addr", {22'd0, ram_addr}, 32'd0);
    check("rst_strobes", {30'd0, ram_re, ram_we}, 32'd0);
    check("rst_cnts", {rd_cnt, wr_cnt}, 32'd0);
    res = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0x12345678 to byte address 0x40.
    txn(1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0, n);
    check("wr_we_cnt", we_cnt, 32'd1);
    check("wr_re_cnt", re_cnt, 32'd0);
    check("wr_addr", {22'd0, we_addr}, 32'h010);
    check("wr_data", we_data, 32'h12345678);
    check("wr_latency", ready_edge - n, 32'd5);
    check("wr_ready_cnt", ready_cnt, 32'd1);
    check("wr_cnt", {16'd0, wr_cnt}, 32'd1);
    check("wr_busy_after", {31'd0, busy}, 32'd0);

    // Read back 0x40.
    txn(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, n);
    check("rd_data", ready_data, 32'h12345678);
    check("rd_latency", ready_edge - n, 32'd5);
    check("rd_re_cnt", re_cnt, 32'd1);
    check("rd_cnt", {16'd0, rd_cnt}, 32'd1);
    check("rd_we_cnt", we_cnt, 32'd1);

    // Read and write together at 0x44: write wins.
    txn(1'b1, 1'b1, 32'h44, 32'hA5A5A5A5, 1'b0, n);
    check("both_we_cnt", we_cnt, 32'd2);
    check("both_re_cnt", re_cnt, 32'd1);
    check("both_addr", {22'd0, we_addr}, 32'h011);
    check("both_data", we_data, 32'hA5A5A5A5);
    check("both_cnts", {rd_cnt, wr_cnt}, {16'd1, 16'd2});
    check("both_rdata_hold", db_rdata, 32'h12345678);

    // Address wrap and byte-offset discard: 0x1043 maps to word 0x010.
    txn(1'b1, 1'b0, 32'h1043, 32'h0, 1'b0, n);
    check("wrap_addr", {22'd0, re_addr}, 32'h010);
    check("wrap_data", ready_data, 32'h12345678);
    check("wrap_rd_cnt", {16'd0, rd_cnt}, 32'd2);

    // Request dropped one cycle after sampling still completes once.
    txn(1'b0, 1'b1, 32'h80, 32'hDEADBEEF, 1'b1, n);
    check("drop_latency", ready_edge - n, 32'd5);
    check("drop_addr", {22'd0, we_addr}, 32'h020);
    check("drop_wr_cnt", {16'd0, wr_cnt}, 32'd3);
    rdy0 = ready_cnt;
    repeat (8) @(negedge clk);
    check("drop_single_ready", ready_cnt, rdy0);
    check("drop_idle", {31'd0, busy}, 32'd0);

    // Reset during WAIT of a write.
    we0 = we_cnt; rdy0 = ready_cnt;
    @(negedge clk);
    db_write = 1'b1; db_addr = 32'h100; db_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    check("mid_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    res = 1'b0; db_write = 1'b0;
    #1;
    check("mid_rst_cnts", {rd_cnt, wr_cnt}, 32'd0);
    check("mid_rst_rdata", db_rdata, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    res = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_no_we", we_cnt, we0);
    check("mid_no_ready", ready_cnt, rdy0);
    txn(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, n);
    check("post_rst_data", ready_data, 32'h12345678);
    check("post_rst_latency", ready_edge - n, 32'd5);
    check("post_rst_cnts", {rd_cnt, wr_cnt}, {16'd1, 16'd0});

    // Zero-wait-state instance: read 0x40.
    re0 = re0_cnt;
    @(negedge clk);
    db_read0 = 1'b1; db_addr0 = 32'h40;
    @(posedge clk); #1;
    n = cyc;
    @(negedge clk);
    db_read0 = 1'b0;
    repeat (6) @(negedge clk);
    check("w0_latency", ready0_edge - n, 32'd3);
    check("w0_data", ready0_data, 32'hCAFEF00D);
    check("w0_ready_cnt", ready0_cnt, 32'd1);
    check("w0_re_cnt", re0_cnt - re0, 32'd1);
    check("w0_rd_cnt", {16'd0, rd_cnt0}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
